bf_cpu_subsystem: RTL and testbench

// Brainfuck execution subsystem: sequencer, data RAM (DATA_COUNT cells) and program ROM in one block.

---
 rtl/bf_cpu_subsystem.sv | 183 ++++++++++++++++++
 tb/tb_bf_cpu_subsystem.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/bf_cpu_subsystem.sv
// Brainfuck sequencer with private data RAM and program ROM; '.' results leave on stdout/stdout_en.
// Latency: '<' '>' 2 cycles, '+' '-' '.' '[' ']' 4 cycles; en low freezes everything, no memory access.
module bf_cpu_subsystem #(
  parameter int    DATA_ADDR_WIDTH  = 16,
  parameter int    DATA_VALUE_WIDTH = 32,
  parameter int    DATA_COUNT       = 1024,
  parameter int    PROG_ADDR_WIDTH  = 16,
  parameter int    PROG_VALUE_WIDTH = 10,
  parameter int    PROG_COUNT       = 2048,
  parameter string PROG_INIT        = "prog.hex"
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       en,
  output logic [7:0] stdout,
  output logic       stdout_en,
  output logic       halted
);

  localparam int DIDX_W = $clog2(DATA_COUNT);
  localparam int PIDX_W = $clog2(PROG_COUNT);
  localparam logic [DATA_ADDR_WIDTH-1:0] DP_MASK = DATA_ADDR_WIDTH'(DATA_COUNT - 1);

  typedef enum logic [2:0] {
    S_CLEAR, S_FETCH, S_DECODE, S_READ, S_EXEC, S_SCAN_FETCH, S_SCAN_DECODE, S_HALT
  } state_t;

  logic [PROG_VALUE_WIDTH-1:0] r_rom [PROG_COUNT];
  logic [DATA_VALUE_WIDTH-1:0] r_ram [DATA_COUNT];
  logic [7:0]                  r_rom_q;
  logic [DATA_VALUE_WIDTH-1:0] r_ram_q;

  state_t                      r_state;
  logic [PROG_ADDR_WIDTH-1:0]  r_pc;
  logic [DATA_ADDR_WIDTH-1:0]  r_dp;
  logic [PROG_ADDR_WIDTH-1:0]  r_depth;
  logic                        r_scan_bwd;
  logic [7:0]                  r_stdout;
  logic                        r_stdout_en;
  logic                        r_halted;

  logic [7:0]                  w_op;
  logic [DIDX_W-1:0]           w_dp_idx;
  logic [PIDX_W-1:0]           w_pc_idx;
  logic [DATA_ADDR_WIDTH-1:0]  w_dp_inc;
  logic [DATA_ADDR_WIDTH-1:0]  w_dp_dec;
  logic [PROG_ADDR_WIDTH-1:0]  w_pc_inc;
  logic [PROG_ADDR_WIDTH-1:0]  w_pc_dec;
  logic                        w_pc_in_range;
  logic                        w_rom_ren;
  logic                        w_ram_ren;
  logic                        w_ram_wen;
  logic [DATA_VALUE_WIDTH-1:0] w_ram_wdat;

  assign w_op          = r_rom_q;
  assign w_dp_idx      = r_dp[DIDX_W-1:0];
  assign w_pc_idx      = r_pc[PIDX_W-1:0];
  assign w_dp_inc      = (r_dp + DATA_ADDR_WIDTH'(1)) & DP_MASK;
  assign w_dp_dec      = (r_dp - DATA_ADDR_WIDTH'(1)) & DP_MASK;
  assign w_pc_inc      = r_pc + PROG_ADDR_WIDTH'(1);
  assign w_pc_dec      = r_pc - PROG_ADDR_WIDTH'(1);
  assign w_pc_in_range = (32'(r_pc) < PROG_COUNT);

  assign w_rom_ren = en && w_pc_in_range && (r_state == S_FETCH || r_state == S_SCAN_FETCH);
  assign w_ram_ren = en && (r_state == S_READ);
  assign w_ram_wen = en && ((r_state == S_CLEAR) ||
                            (r_state == S_DECODE && w_op == ",") ||
                            (r_state == S_EXEC && (w_op == "+" || w_op == "-")));

  always_comb begin
    w_ram_wdat = '0;
    if (r_state == S_EXEC && w_op == "+")
      w_ram_wdat = r_ram_q + DATA_VALUE_WIDTH'(1);
    else if (r_state == S_EXEC && w_op == "-")
      w_ram_wdat = r_ram_q - DATA_VALUE_WIDTH'(1);
  end

  // Single-port RAM: read and write share the data pointer.
  always_ff @(posedge clk) begin
    if (w_rom_ren) r_rom_q <= r_rom[w_pc_idx][7:0];
    if (w_ram_ren) r_ram_q <= r_ram[w_dp_idx];
    if (w_ram_wen) r_ram[w_dp_idx] <= w_ram_wdat;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_CLEAR;
      r_pc        <= '0;
      r_dp        <= '0;
      r_depth     <= '0;
      r_scan_bwd  <= 1'b0;
      r_stdout    <= '0;
      r_stdout_en <= 1'b0;
      r_halted    <= 1'b0;
    end else if (en) begin
      r_stdout_en <= 1'b0;
      case (r_state)
        S_CLEAR: begin
          r_dp <= w_dp_inc;
          if (w_dp_idx == DIDX_W'(DATA_COUNT - 1)) r_state <= S_FETCH;
        end
        S_FETCH: begin
          if (w_pc_in_range) begin
            r_state <= S_DECODE;
          end else begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end
        end
        S_DECODE: begin
          case (w_op)
            ">":     begin r_dp <= w_dp_inc; r_pc <= w_pc_inc; r_state <= S_FETCH; end
            "<":     begin r_dp <= w_dp_dec; r_pc <= w_pc_inc; r_state <= S_FETCH; end
            "+", "-", ".", "[", "]": r_state <= S_READ;
            8'h00:   begin r_state <= S_HALT; r_halted <= 1'b1; end
            default: begin r_pc <= w_pc_inc; r_state <= S_FETCH; end
          endcase
        end
        S_READ: r_state <= S_EXEC;
        S_EXEC: begin
          r_pc    <= w_pc_inc;
          r_state <= S_FETCH;
          if (w_op == ".") begin
            r_stdout    <= r_ram_q[7:0];
            r_stdout_en <= 1'b1;
          end else if (w_op == "[" && r_ram_q == '0) begin
            r_depth    <= PROG_ADDR_WIDTH'(1);
            r_scan_bwd <= 1'b0;
            r_state    <= S_SCAN_FETCH;
          end else if (w_op == "]" && r_ram_q != '0) begin
            r_depth    <= PROG_ADDR_WIDTH'(1);
            r_scan_bwd <= 1'b1;
            r_pc       <= w_pc_dec;
            r_state    <= S_SCAN_FETCH;
            if (r_pc == '0) begin
              r_state  <= S_HALT;
              r_halted <= 1'b1;
            end
          end
        end
        S_SCAN_FETCH: begin
          if (w_pc_in_range) begin
            r_state <= S_SCAN_DECODE;
          end else begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end
        end
        S_SCAN_DECODE: begin
          // Depth reaching zero resumes execution just after the matching bracket.
          if (!r_scan_bwd) begin
            r_pc    <= w_pc_inc;
            r_state <= S_SCAN_FETCH;
            if (w_op == "[") begin
              r_depth <= r_depth + PROG_ADDR_WIDTH'(1);
            end else if (w_op == "]") begin
              r_depth <= r_depth - PROG_ADDR_WIDTH'(1);
              if (r_depth == PROG_ADDR_WIDTH'(1)) r_state <= S_FETCH;
            end
          end else if (w_op == "[" && r_depth == PROG_ADDR_WIDTH'(1)) begin
            r_depth <= '0;
            r_pc    <= w_pc_inc;
            r_state <= S_FETCH;
          end else if (r_pc == '0) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end else begin
            r_pc    <= w_pc_dec;
            r_state <= S_SCAN_FETCH;
            if (w_op == "[")      r_depth <= r_depth - PROG_ADDR_WIDTH'(1);
            else if (w_op == "]") r_depth <= r_depth + PROG_ADDR_WIDTH'(1);
          end
        end
        default: r_state <= S_HALT;
      endcase
    end
  end

  assign stdout    = r_stdout;
  assign stdout_en = r_stdout_en;
  assign halted    = r_halted;

endmodule

// File: tb/tb_bf_cpu_subsystem.sv
// Directed programs against bf_cpu_subsystem; ROM is preloaded directly, output bytes are scoreboarded.
module tb_bf_cpu_subsystem;

  logic       clk = 1'b0;
  logic       resetn;
  logic       en;
  logic [7:0] stdout;
  logic       stdout_en;
  logic       halted;

  int n_checks = 0;
  int n_errors = 0;
  int cyc;

  logic [7:0] outq  [$];
  logic [7:0] exp_q [$];
  logic       prev_se = 1'b0;

  always #5 clk = ~clk;

  bf_cpu_subsystem #(.PROG_INIT("")) dut (
    .clk       (clk),
    .resetn    (resetn),
    .en        (en),
    .stdout    (stdout),
    .stdout_en (stdout_en),
    .halted    (halted)
  );

  // One entry per strobe, however many disabled cycles it spans.
  always @(negedge clk) begin
    if (stdout_en && !prev_se) outq.push_back(stdout);
    prev_se = stdout_en;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_bytes(input int n, input logic [7:0] b0, input logic [7:0] b1);
    exp_q.delete();
    if (n > 0) exp_q.push_back(b0);
    if (n > 1) exp_q.push_back(b1);
  endtask

  task automatic check_out(input string tag);
    chk({tag, "_count"}, 64'(outq.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), (i < outq.size()) ? outq[i] : 8'hxx, exp_q[i]);
  endtask

  task automatic fill_rom(input logic [7:0] c);
    for (int i = 0; i < 2048; i++) dut.r_rom[i] = {2'b10, c};
  endtask

  task automatic load_prog(input string s);
    fill_rom(8'h00);
    for (int i = 0; i < s.len(); i++) dut.r_rom[i] = {2'b10, s.getc(i)};
  endtask

  task automatic release_reset();
    outq.delete();
    @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic wait_halt(input bit tog, input int budget, output int n);
    n = 0;
    while (!halted && n < budget) begin
      @(posedge clk);
      #1;
      if (tog) en = ~en;
      n++;
    end
  endtask

  task automatic run(input string tag, input string prog, input bit tog, input int budget, output int n);
    resetn = 1'b0;
    en     = 1'b1;
    load_prog(prog);
    release_reset();
    wait_halt(tog, budget, n);
    chk({tag, "_halted"}, 64'(halted), 64'd1);
  endtask

  initial begin
    resetn = 1'b0;
    en     = 1'b1;
    #12;
    chk("rst_stdout", 64'(stdout), 64'h0);
    chk("rst_stdout_en", 64'(stdout_en), 64'h0);
    chk("rst_halted", 64'(halted), 64'h0);

    run("t1", "+++.", 1'b0, 3000, cyc);
    expect_bytes(1, 8'h03, 8'h00);
    check_out("t1");
    chk("t1_cycles", 64'(cyc), 64'd1042);

    run("t2a", "<-.", 1'b0, 3000, cyc);
    expect_bytes(1, 8'hFF, 8'h00);
    check_out("t2a");
    chk("t2a_cell1023", 64'(dut.r_ram[1023]), 64'hFFFF_FFFF);

    run("t2b", "<-.+.", 1'b0, 3000, cyc);
    expect_bytes(2, 8'hFF, 8'h00);
    check_out("t2b");

    run("t3", "++[->+<]>.", 1'b0, 4000, cyc);
    expect_bytes(1, 8'h02, 8'h00);
    check_out("t3");
    chk("t3_cell0", 64'(dut.r_ram[0]), 64'h0);
    chk("t3_cell1", 64'(dut.r_ram[1]), 64'h2);

    run("t4", "[.+]+.", 1'b0, 3000, cyc);
    expect_bytes(1, 8'h01, 8'h00);
    check_out("t4");

    run("tcomma", "+++,.", 1'b0, 3000, cyc);
    expect_bytes(1, 8'h00, 8'h00);
    check_out("tcomma");

    run("t5", "[[", 1'b0, 20000, cyc);
    expect_bytes(0, 8'h00, 8'h00);
    check_out("t5");

    // Whole ROM of NOPs with a final '.', so pc runs off the end of the ROM.
    resetn = 1'b0;
    en     = 1'b1;
    fill_rom(" ");
    dut.r_rom[2047] = {2'b10, 8'h2E};
    release_reset();
    wait_halt(1'b0, 20000, cyc);
    chk("tend_halted", 64'(halted), 64'd1);
    chk("tend_cycles", 64'(cyc), 64'd5123);
    expect_bytes(1, 8'h00, 8'h00);
    check_out("tend");

    run("t6", "+.+.", 1'b0, 3000, cyc);
    expect_bytes(2, 8'h01, 8'h02);
    check_out("t6");
    chk("t6_cycles", 64'(cyc), 64'd1042);

    run("t6en", "+.+.", 1'b1, 6000, cyc);
    check_out("t6en");
    chk("t6en_cycles", 64'(cyc), 64'd2083);

    resetn = 1'b0;
    en     = 1'b1;
    load_prog("+.+.");
    release_reset();
    cyc = 0;
    while (outq.size() == 0 && cyc < 3000) begin
      @(posedge clk);
      #1 cyc++;
    end
    chk("t7_first", 64'(outq.size()), 64'd1);
    resetn = 1'b0;
    #2;
    chk("t7_rst_stdout", 64'(stdout), 64'h0);
    chk("t7_rst_halted", 64'(halted), 64'h0);
    release_reset();
    wait_halt(1'b0, 3000, cyc);
    chk("t7_halted", 64'(halted), 64'd1);
    expect_bytes(2, 8'h01, 8'h02);
    check_out("t7");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
